// File: rtl/uart_result_sender_pkg.sv
// Shared definitions for the result-sender frame path: sync byte, frame FSM
// encoding, baud divider helper and frame layout shared with the receive-side loader.
package uart_result_sender_pkg;

  localparam logic [7:0]  SYNC_BYTE            = 8'hA5;
  // SYNC + size + checksum surround the N*N data bytes
  localparam int unsigned FRAME_OVERHEAD_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SIZE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_CSUM,
    ST_FIN
  } state_e;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 bit serializer: start bit, 8 data bits LSB first, stop bit, each held DIV clocks.
module uart_tx_serializer #(
  parameter int unsigned DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       ready,
  output logic       tx_line
);

  localparam int unsigned CW = $clog2(DIV);

  logic          busy_q, busy_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      shift_q <= '1;
      bit_q   <= '0;
      baud_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    if (!busy_q) begin
      // Baud counter restarts on load so the start bit is a full DIV clocks
      if (load) begin
        busy_d  = 1'b1;
        shift_d = {1'b1, din, 1'b0};
        bit_d   = '0;
        baud_d  = '0;
      end
    end else if (baud_q == CW'(DIV - 1)) begin
      baud_d  = '0;
      shift_d = {1'b1, shift_q[9:1]};
      bit_d   = bit_q + 4'd1;
      if (bit_q == 4'd9) busy_d = 1'b0;
    end else begin
      baud_d = baud_q + CW'(1);
    end
  end

  assign ready   = !busy_q;
  assign tx_line = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/uart_result_sender.sv
// Reads result matrix C from memory and sends it over UART as one framed packet:
// SYNC, N, N*N data bytes (row-major), 8-bit checksum of N and data.
module uart_result_sender
  import uart_result_sender_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned MAX_N  = 8,
  parameter int unsigned ADDR_W = 6,
  parameter logic [7:0]  SYNC   = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        size,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              tx_line,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned IW  = $clog2(MAX_N) + 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  n_q, n_d, i_q, i_d, j_q, j_d;
  logic [7:0]     csum_q, csum_d, data_q, data_d;
  logic           ser_load, ser_ready;
  logic [7:0]     ser_din;
  logic           row_end, last_elem;

  uart_tx_serializer #(.DIV(DIV)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .din     (ser_din),
    .ready   (ser_ready),
    .tx_line (tx_line)
  );

  assign row_end   = (j_q == n_q - IW'(1));
  assign last_elem = row_end && (i_q == n_q - IW'(1));
  assign mem_addr  = ADDR_W'(32'(i_q) * 32'(MAX_N) + 32'(j_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      csum_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    csum_d  = csum_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        n_d     = (size > 8'(MAX_N)) ? IW'(MAX_N) : IW'(size);
        i_d     = '0;
        j_d     = '0;
        csum_d  = '0;
        state_d = ST_SYNC;
      end
      ST_SYNC: if (ser_ready) state_d = ST_SIZE;
      ST_SIZE: if (ser_ready) begin
        csum_d  = csum_q + 8'(n_q);
        state_d = (n_q == '0) ? ST_CSUM : ST_FETCH;
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        data_d  = mem_data;
        state_d = ST_SEND;
      end
      // The next element is fetched while this one is still on the line
      ST_SEND: if (ser_ready) begin
        csum_d = csum_q + data_q;
        if (row_end) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
        state_d = last_elem ? ST_CSUM : ST_FETCH;
      end
      ST_CSUM: if (ser_ready) state_d = ST_FIN;
      ST_FIN:  if (ser_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = 1'b0;
    ser_load = 1'b0;
    ser_din  = SYNC;
    done     = 1'b0;
    busy     = (state_q != ST_IDLE);
    unique case (state_q)
      ST_SYNC:  ser_load = ser_ready;
      ST_SIZE: begin
        ser_load = ser_ready;
        ser_din  = 8'(n_q);
      end
      ST_FETCH: mem_rd = 1'b1;
      ST_SEND: begin
        ser_load = ser_ready;
        ser_din  = data_q;
      end
      ST_CSUM: begin
        ser_load = ser_ready;
        ser_din  = csum_q;
      end
      ST_FIN:  done = ser_ready;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_result_sender.sv
// Scoreboard bench for uart_result_sender: decodes the serial line, checks bytes,
// bit timing, read addresses, done pulses and reset abort.
module tb_uart_result_sender;

  localparam int unsigned CLK_HZ = 16;
  localparam int unsigned BAUD   = 1;
  localparam int unsigned MAX_N  = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int          BIT_T  = 16;
  localparam int          BYTE_T = 10 * BIT_T;

  logic              clk = 1'b0;
  logic              rst, start, mem_rd, tx_line, busy, done;
  logic [7:0]        size, mem_data;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  uart_result_sender #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .MAX_N  (MAX_N),
    .ADDR_W (ADDR_W),
    .SYNC   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .size     (size),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .tx_line  (tx_line),
    .busy     (busy),
    .done     (done)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]        mem [64];
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int rd_cnt = 0, done_cnt = 0, rx_cnt = 0, extra_rx = 0, extra_rd = 0, frame_got = 0;

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
    if (!rst && mem_rd) begin
      rd_cnt++;
      if (exp_addr_q.size() == 0) extra_rd++;
      else check_eq("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
    end
  end

  // Line decoder: one sample per clock, every sample of a bit must match its first
  bit       rx_active = 1'b0;
  int       rx_n = 0, idle_n = 0, glitches = 0;
  logic [9:0] rx_bits;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      rx_n      = 0;
      idle_n    = 0;
    end else if (!rx_active) begin
      if (tx_line == 1'b0) begin
        if (frame_got > 0) check_eq("gap_le2", 32'(idle_n <= 2), 32'd1);
        rx_active  = 1'b1;
        rx_n       = 1;
        rx_bits[0] = 1'b0;
        glitches   = 0;
      end else begin
        idle_n++;
      end
    end else begin
      if (rx_n % BIT_T == 0) rx_bits[rx_n / BIT_T] = tx_line;
      else if (tx_line !== rx_bits[rx_n / BIT_T]) glitches++;
      rx_n++;
      if (rx_n == BYTE_T) begin
        rx_active = 1'b0;
        idle_n    = 0;
        frame_got++;
        rx_cnt++;
        check_eq("stop_bit", 32'(rx_bits[9]), 32'd1);
        check_eq("bit_hold", 32'(glitches), 32'd0);
        if (exp_q.size() == 0) extra_rx++;
        else check_eq("byte", 32'(rx_bits[8:1]), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic queue_frame(input logic [7:0] sz, output int n);
    logic [7:0] cs, b;
    n = (sz > 8'(MAX_N)) ? int'(MAX_N) : int'(sz);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n));
    cs = 8'(n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        b = mem[i * MAX_N + j];
        exp_q.push_back(b);
        exp_addr_q.push_back(ADDR_W'(i * MAX_N + j));
        cs = cs + b;
      end
    end
    exp_q.push_back(cs);
    frame_got = 0;
    extra_rx  = 0;
    extra_rd  = 0;
  endtask

  task automatic run_frame(input logic [7:0] sz, input bit repulse, output int k);
    int n, d0, budget;
    bit seen;
    queue_frame(sz, n);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    size  = sz;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_set", 32'(busy), 32'd1);
    budget = (n * n + 3) * BYTE_T + 200;
    k = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      start = repulse && (k == 300);
      if (repulse && k == 300) size = 8'd5;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check_eq("done_seen", 32'(seen), 32'd1);
    repeat (20) @(negedge clk);
    check_eq("done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("bytes_left", 32'(exp_q.size()), 32'd0);
    check_eq("reads_left", 32'(exp_addr_q.size()), 32'd0);
    check_eq("extra_bytes", 32'(extra_rx), 32'd0);
    check_eq("extra_reads", 32'(extra_rd), 32'd0);
    check_eq("busy_clear", 32'(busy), 32'd0);
    check_eq("line_idle", 32'(tx_line), 32'd1);
  endtask

  initial begin
    int k, rd0, d0, rx0, n, w;
    rst   = 1'b1;
    start = 1'b0;
    size  = 8'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h01; mem[1] = 8'h02; mem[8] = 8'h03; mem[9] = 8'h04;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx_line), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd", 32'(mem_rd), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(8'd2, 1'b0, k);
    check_eq("frame_time", 32'(k >= 7 * BYTE_T - 14 && k <= 7 * BYTE_T + 14), 32'd1);

    rd0 = rd_cnt;
    run_frame(8'd0, 1'b0, k);
    check_eq("n0_reads", 32'(rd_cnt - rd0), 32'd0);

    rd0 = rd_cnt;
    run_frame(8'd20, 1'b0, k);
    check_eq("n8_reads", 32'(rd_cnt - rd0), 32'd64);

    run_frame(8'd3, 1'b1, k);

    // Reset during a data byte must abort the frame with no done pulse
    queue_frame(8'd2, n);
    d0  = done_cnt;
    rx0 = rx_cnt;
    @(negedge clk);
    start = 1'b1;
    size  = 8'd2;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(rx_cnt >= rx0 + 3 && tx_line == 1'b0) && w < 6 * BYTE_T) begin
      @(negedge clk);
      w++;
    end
    check_eq("mid_byte_reached", 32'(w < 6 * BYTE_T), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_tx", 32'(tx_line), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rd", 32'(mem_rd), 32'd0);
    check_eq("abort_addr", 32'(mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_addr_q.delete();
    frame_got = 0;
    extra_rx  = 0;
    extra_rd  = 0;
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("abort_quiet", 32'(extra_rx), 32'd0);
    check_eq("abort_no_rd", 32'(extra_rd), 32'd0);

    run_frame(8'd1, 1'b0, k);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
